// File: rtl/tx_on_pkg.sv
// Shared constants and types for the multi-channel TX-on detector.
// COUNT_SCALE converts microsecond settings into clock cycles.
package tx_on_pkg;

  localparam int CLOCK_SPEED = 10;
  localparam int COUNT_SCALE = CLOCK_SPEED;
  localparam int STRETCH     = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    BB_ON = 1'b1
  } tx_state_e;

endpackage

// File: rtl/tx_on_detection_ch.sv
// One TX chain: burst FSM, ongoing stretch, latched config,
// RF window counter and baseband watchdog.
module tx_on_detection_ch
  import tx_on_pkg::*;
#(
  parameter int DLY_W = 8,
  parameter int EXT_W = 4,
  parameter int TO_W  = 12,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             search,
  input  logic             enable,
  input  logic             fifo_empty,
  input  logic             timeout_clear,
  input  logic [DLY_W-1:0] delay_top,
  input  logic [EXT_W-1:0] ext_top,
  input  logic [TO_W-1:0]  timeout_top,
  output logic             bb_on_stretch,
  output logic             rf_on,
  output logic             pulse_start,
  output logic             pulse_end,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] SCALE = CNT_W'(COUNT_SCALE);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  tx_state_e          state;
  tx_state_e          state_nxt;
  logic               empty_d1;
  logic [STRETCH-1:0] bb_dly;
  logic               bb_on;
  logic               running;
  logic               wd_fire;
  logic [CNT_W-1:0]   d_now;
  logic [CNT_W-1:0]   e_now;
  logic [CNT_W-1:0]   t_now;
  logic [CNT_W-1:0]   d_lat;
  logic [CNT_W-1:0]   e_lat;
  logic [CNT_W-1:0]   t_lat;
  logic [CNT_W-1:0]   t_eff;
  logic [CNT_W-1:0]   rf_cnt;
  logic [CNT_W-1:0]   wd_cnt;

  assign d_now = CNT_W'(delay_top) * SCALE;
  assign e_now = d_now + CNT_W'(ext_top) * SCALE;
  assign t_now = CNT_W'(timeout_top) * SCALE;

  assign bb_on         = (state == BB_ON);
  assign pulse_start   = bb_on & ~bb_dly[0];
  assign pulse_end     = ~bb_on & bb_dly[0];
  assign bb_on_stretch = bb_on | (|bb_dly);

  // The limit is only latched at the start edge, so that cycle
  // must see the live value for a one-cycle watchdog to work.
  assign t_eff   = pulse_start ? t_now : t_lat;
  assign wd_fire = bb_on && (t_eff != '0)
                   && (wd_cnt == t_eff - ONE);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (search && enable && empty_d1 && !fifo_empty)
          state_nxt = BB_ON;
      end
      BB_ON: begin
        if ((!search && !empty_d1 && fifo_empty) || wd_fire)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      empty_d1 <= 1'b0;
      bb_dly   <= '0;
      d_lat    <= '0;
      e_lat    <= '0;
      t_lat    <= '0;
      rf_cnt   <= '0;
      running  <= 1'b0;
      rf_on    <= 1'b0;
      wd_cnt   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      empty_d1 <= fifo_empty;
      bb_dly   <= {bb_dly[STRETCH-2:0], bb_on};
      if (pulse_start) begin
        d_lat <= d_now;
        e_lat <= e_now;
        t_lat <= t_now;
      end
      if (pulse_start || pulse_end)
        rf_cnt <= '0;
      else if (rf_cnt != e_lat + ONE)
        rf_cnt <= rf_cnt + ONE;
      if (pulse_start)
        running <= 1'b1;
      else if (pulse_end)
        running <= 1'b0;
      if (!(pulse_start || pulse_end)) begin
        if (running && rf_cnt == d_lat)
          rf_on <= 1'b1;
        else if (!running && rf_cnt == e_lat)
          rf_on <= 1'b0;
      end
      wd_cnt <= bb_on ? wd_cnt + ONE : '0;
      if (timeout_clear)
        timeout <= 1'b0;
      else if (wd_fire)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/tx_on_multi_detection.sv
// Multi-channel TX-on detector: shared search flag, one
// detector per chain, OR of the stretched baseband windows.
module tx_on_multi_detection
  import tx_on_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DLY_W  = 8,
  parameter int EXT_W  = 4,
  parameter int TO_W   = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DLY_W-1:0]  bb_rf_delay_count_top,
  input  logic [EXT_W-1:0]  rf_end_ext_count_top,
  input  logic [TO_W-1:0]   bb_timeout_top,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic              phy_tx_started,
  input  logic              phy_tx_done,
  input  logic [NUM_CH-1:0] tx_iq_fifo_empty,
  input  logic              timeout_clear,
  output logic              tx_bb_is_ongoing,
  output logic [NUM_CH-1:0] tx_bb_is_ongoing_ch,
  output logic [NUM_CH-1:0] tx_rf_is_ongoing,
  output logic [NUM_CH-1:0] pulse_tx_bb_start,
  output logic [NUM_CH-1:0] pulse_tx_bb_end,
  output logic [NUM_CH-1:0] tx_bb_timeout
);

  logic search;

  always_ff @(posedge clk) begin
    if (rst)
      search <= 1'b0;
    else if (phy_tx_started)
      search <= 1'b1;
    else if (phy_tx_done)
      search <= 1'b0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tx_on_detection_ch #(
      .DLY_W (DLY_W),
      .EXT_W (EXT_W),
      .TO_W  (TO_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .search        (search),
      .enable        (ch_enable[i]),
      .fifo_empty    (tx_iq_fifo_empty[i]),
      .timeout_clear (timeout_clear),
      .delay_top     (bb_rf_delay_count_top),
      .ext_top       (rf_end_ext_count_top),
      .timeout_top   (bb_timeout_top),
      .bb_on_stretch (tx_bb_is_ongoing_ch[i]),
      .rf_on         (tx_rf_is_ongoing[i]),
      .pulse_start   (pulse_tx_bb_start[i]),
      .pulse_end     (pulse_tx_bb_end[i]),
      .timeout       (tx_bb_timeout[i])
    );
  end

  assign tx_bb_is_ongoing = |tx_bb_is_ongoing_ch;

endmodule

// File: tb/tb_tx_on_multi_detection.sv
// Directed bench for tx_on_multi_detection (COUNT_SCALE = 10).
// An edge monitor timestamps pulses and RF/BB window edges.
module tb_tx_on_multi_detection;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  dly_top;
  logic [3:0]  ext_top;
  logic [11:0] to_top;
  logic [1:0]  ch_en;
  logic        started;
  logic        done;
  logic [1:0]  empty;
  logic        to_clr;
  logic        bb_any;
  logic [1:0]  bb_ch;
  logic [1:0]  rf;
  logic [1:0]  p_start;
  logic [1:0]  p_end;
  logic [1:0]  to_flag;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int n_start [2];
  int n_end   [2];
  int n_rf_up [2];
  int t_start [2];
  int t_end   [2];
  int t_rf_up [2];
  int t_rf_dn [2];
  int t_bb_dn [2];
  int or_err;
  logic [1:0] rf_prev = '0;
  logic [1:0] bb_prev = '0;

  tx_on_multi_detection dut (
    .clk                   (clk),
    .rst                   (rst),
    .bb_rf_delay_count_top (dly_top),
    .rf_end_ext_count_top  (ext_top),
    .bb_timeout_top        (to_top),
    .ch_enable             (ch_en),
    .phy_tx_started        (started),
    .phy_tx_done           (done),
    .tx_iq_fifo_empty      (empty),
    .timeout_clear         (to_clr),
    .tx_bb_is_ongoing      (bb_any),
    .tx_bb_is_ongoing_ch   (bb_ch),
    .tx_rf_is_ongoing      (rf),
    .pulse_tx_bb_start     (p_start),
    .pulse_tx_bb_end       (p_end),
    .tx_bb_timeout         (to_flag)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (p_start[c]) begin
        n_start[c]++;
        t_start[c] = cyc;
      end
      if (p_end[c]) begin
        n_end[c]++;
        t_end[c] = cyc;
      end
      if (rf[c] && !rf_prev[c]) begin
        n_rf_up[c]++;
        t_rf_up[c] = cyc;
      end
      if (!rf[c] && rf_prev[c])
        t_rf_dn[c] = cyc;
      if (!bb_ch[c] && bb_prev[c])
        t_bb_dn[c] = cyc;
    end
    if (bb_any !== (|bb_ch))
      or_err++;
    rf_prev = rf;
    bb_prev = bb_ch;
  end

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    for (int c = 0; c < 2; c++) begin
      n_start[c] = 0;
      n_end[c]   = 0;
      n_rf_up[c] = 0;
      t_start[c] = -1;
      t_end[c]   = -1;
      t_rf_up[c] = -1;
      t_rf_dn[c] = -1;
      t_bb_dn[c] = -1;
    end
    or_err = 0;
  endtask

  task automatic pulse_started();
    started = 1'b1;
    run(1);
    started = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    run(1);
    done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run(2);
    checks++;
    if (bb_any !== 1'b0) begin
      errs++;
      $display("FAIL reset_bb_any got=%b exp=0", bb_any);
    end
    checks++;
    if (bb_ch !== 2'b00) begin
      errs++;
      $display("FAIL reset_bb_ch got=%b exp=00", bb_ch);
    end
    checks++;
    if (rf !== 2'b00) begin
      errs++;
      $display("FAIL reset_rf got=%b exp=00", rf);
    end
    checks++;
    if ({p_start, p_end} !== 4'b0) begin
      errs++;
      $display("FAIL reset_pulses got=%b exp=0000",
               {p_start, p_end});
    end
    checks++;
    if (to_flag !== 2'b00) begin
      errs++;
      $display("FAIL reset_timeout got=%b exp=00", to_flag);
    end
    rst = 1'b0;
    run(1);
  endtask

  task automatic test_single_burst();
    dly_top = 8'd2;
    ext_top = 4'd1;
    to_top  = 12'd0;
    ch_en   = 2'b01;
    clear_mon();
    pulse_started();
    empty[0] = 1'b0;
    run(1);
    pulse_done();
    run(100);
    empty[0] = 1'b1;
    run(60);
    checks++;
    if (n_start[0] != 1 || n_end[0] != 1) begin
      errs++;
      $display("FAIL single_pulses got=%0d/%0d exp=1/1",
               n_start[0], n_end[0]);
    end
    checks++;
    if (t_end[0] - t_start[0] != 102) begin
      errs++;
      $display("FAIL single_len got=%0d exp=102",
               t_end[0] - t_start[0]);
    end
    checks++;
    if (t_rf_up[0] - t_start[0] != 22) begin
      errs++;
      $display("FAIL single_rf_up got=%0d exp=22",
               t_rf_up[0] - t_start[0]);
    end
    checks++;
    if (t_rf_dn[0] - t_end[0] != 32) begin
      errs++;
      $display("FAIL single_rf_dn got=%0d exp=32",
               t_rf_dn[0] - t_end[0]);
    end
    checks++;
    if (t_bb_dn[0] - t_end[0] != 4) begin
      errs++;
      $display("FAIL single_stretch got=%0d exp=4",
               t_bb_dn[0] - t_end[0]);
    end
  endtask

  task automatic test_short_burst();
    clear_mon();
    pulse_started();
    empty[0] = 1'b0;
    run(1);
    pulse_done();
    run(8);
    empty[0] = 1'b1;
    run(50);
    checks++;
    if (n_start[0] != 1 || n_end[0] != 1) begin
      errs++;
      $display("FAIL short_pulses got=%0d/%0d exp=1/1",
               n_start[0], n_end[0]);
    end
    checks++;
    if (t_end[0] - t_start[0] != 10) begin
      errs++;
      $display("FAIL short_len got=%0d exp=10",
               t_end[0] - t_start[0]);
    end
    checks++;
    if (n_rf_up[0] != 0) begin
      errs++;
      $display("FAIL short_rf got=%0d rises exp=0",
               n_rf_up[0]);
    end
  endtask

  task automatic test_two_channels();
    ch_en = 2'b11;
    clear_mon();
    pulse_started();
    empty[0] = 1'b0;
    run(5);
    empty[1] = 1'b0;
    run(1);
    pulse_done();
    run(50);
    empty[0] = 1'b1;
    run(5);
    empty[1] = 1'b1;
    run(60);
    checks++;
    if (n_start[1] != 1 || n_end[1] != 1) begin
      errs++;
      $display("FAIL two_ch1_pulses got=%0d/%0d exp=1/1",
               n_start[1], n_end[1]);
    end
    checks++;
    if (t_start[1] - t_start[0] != 5) begin
      errs++;
      $display("FAIL two_start_gap got=%0d exp=5",
               t_start[1] - t_start[0]);
    end
    checks++;
    if (t_end[1] - t_end[0] != 5) begin
      errs++;
      $display("FAIL two_end_gap got=%0d exp=5",
               t_end[1] - t_end[0]);
    end
    checks++;
    if (t_rf_up[1] - t_start[1] != 22) begin
      errs++;
      $display("FAIL two_rf1_up got=%0d exp=22",
               t_rf_up[1] - t_start[1]);
    end
    checks++;
    if (t_rf_dn[1] - t_end[1] != 32) begin
      errs++;
      $display("FAIL two_rf1_dn got=%0d exp=32",
               t_rf_dn[1] - t_end[1]);
    end
    checks++;
    if (or_err != 0) begin
      errs++;
      $display("FAIL two_or got=%0d bad cycles exp=0",
               or_err);
    end
    ch_en = 2'b01;
    clear_mon();
    pulse_started();
    empty = 2'b00;
    run(1);
    pulse_done();
    run(20);
    empty = 2'b11;
    run(60);
    checks++;
    if (n_start[1] != 0 || n_start[0] != 1) begin
      errs++;
      $display("FAIL two_disabled got=%0d/%0d exp=1/0",
               n_start[0], n_start[1]);
    end
  endtask

  task automatic test_watchdog();
    to_top = 12'd3;
    clear_mon();
    pulse_started();
    empty[0] = 1'b0;
    run(1);
    pulse_done();
    run(50);
    checks++;
    if (n_end[0] != 1 || t_end[0] - t_start[0] != 30) begin
      errs++;
      $display("FAIL wd_end got=%0d ends len=%0d exp=1/30",
               n_end[0], t_end[0] - t_start[0]);
    end
    checks++;
    if (to_flag !== 2'b01) begin
      errs++;
      $display("FAIL wd_flag got=%b exp=01", to_flag);
    end
    to_top = 12'd0;
    run(10);
    checks++;
    if (to_flag !== 2'b01) begin
      errs++;
      $display("FAIL wd_sticky got=%b exp=01", to_flag);
    end
    to_clr = 1'b1;
    run(1);
    to_clr = 1'b0;
    checks++;
    if (to_flag !== 2'b00) begin
      errs++;
      $display("FAIL wd_clear got=%b exp=00", to_flag);
    end
    empty[0] = 1'b1;
    run(60);
  endtask

  task automatic test_cfg_change();
    clear_mon();
    started = 1'b1;
    done    = 1'b1;
    run(1);
    started = 1'b0;
    done    = 1'b0;
    empty[0] = 1'b0;
    run(2);
    dly_top = 8'd5;
    ext_top = 4'd0;
    run(3);
    checks++;
    if (n_start[0] != 1) begin
      errs++;
      $display("FAIL cfg_search got=%0d starts exp=1",
               n_start[0]);
    end
    pulse_done();
    run(40);
    empty[0] = 1'b1;
    run(60);
    checks++;
    if (t_rf_up[0] - t_start[0] != 22) begin
      errs++;
      $display("FAIL cfg_rf_up got=%0d exp=22",
               t_rf_up[0] - t_start[0]);
    end
    checks++;
    if (t_rf_dn[0] - t_end[0] != 32) begin
      errs++;
      $display("FAIL cfg_rf_dn got=%0d exp=32",
               t_rf_dn[0] - t_end[0]);
    end
    dly_top = 8'd2;
    ext_top = 4'd1;
  endtask

  task automatic test_reset_mid();
    pulse_started();
    empty[0] = 1'b0;
    run(30);
    checks++;
    if (rf[0] !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_rf_on got=%b exp=1", rf[0]);
    end
    clear_mon();
    rst = 1'b1;
    run(1);
    checks++;
    if ({bb_any, bb_ch, rf, p_start, p_end, to_flag}
        !== 11'b0) begin
      errs++;
      $display("FAIL rstmid_outputs got=%b exp=0",
               {bb_any, bb_ch, rf, p_start, p_end, to_flag});
    end
    rst = 1'b0;
    run(10);
    checks++;
    if (n_end[0] != 0) begin
      errs++;
      $display("FAIL rstmid_no_end got=%0d exp=0", n_end[0]);
    end
    empty[0] = 1'b1;
    run(5);
  endtask

  initial begin
    rst     = 1'b1;
    dly_top = '0;
    ext_top = '0;
    to_top  = '0;
    ch_en   = '0;
    started = 1'b0;
    done    = 1'b0;
    empty   = 2'b11;
    to_clr  = 1'b0;
    clear_mon();
    test_reset();
    test_single_burst();
    test_short_burst();
    test_two_channels();
    test_watchdog();
    test_cfg_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
